// File: rtl/event_counter_scheduler.sv
// Shares one event counter among NUM_REQ requesters: round-robin grant, count TICKs
// up to the owner's latched target, then pulse DONE back to that owner.
module event_counter_scheduler #(
  parameter int NUM_REQ      = 4,
  parameter int TARGET_WIDTH = 8,
  localparam int IDX_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [NUM_REQ-1:0]              REQ,
  input  logic [NUM_REQ*TARGET_WIDTH-1:0] REQ_TARGET,
  input  logic                            TICK,
  output logic [NUM_REQ-1:0]              GRANT,
  output logic [IDX_W-1:0]                GRANT_IDX,
  output logic [NUM_REQ-1:0]              DONE,
  output logic                            BUSY,
  output logic [TARGET_WIDTH-1:0]         COUNTER
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COUNT,
    ST_DONE
  } state_t;

  state_t state, next_state;

  logic [NUM_REQ-1:0]      grant_q, grant_n;
  logic [IDX_W-1:0]        idx_q, idx_n;
  logic [NUM_REQ-1:0]      done_q, done_n;
  logic                    busy_q, busy_n;
  logic [TARGET_WIDTH-1:0] counter_q, counter_n;
  logic [TARGET_WIDTH-1:0] tgt_q, tgt_n;
  logic [IDX_W-1:0]        last_q, last_n;

  logic [IDX_W-1:0] pick, cand;
  logic             found;
  logic             owner_req;
  logic             at_target;

  // Round-robin search starting just after the previous owner.
  always_comb begin
    pick  = last_q;
    cand  = last_q;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(last_q) + k) % NUM_REQ);
      if (!found && REQ[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  assign owner_req = REQ[idx_q];
  assign at_target = (counter_q == tgt_q);

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (|REQ) begin
          next_state = ST_COUNT;
        end
      end
      ST_COUNT: begin
        if (!owner_req) begin
          next_state = ST_IDLE;
        end else if (at_target) begin
          next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Abort outranks completion, and completion outranks counting, so COUNTER never passes tgt.
  always_comb begin
    grant_n   = grant_q;
    idx_n     = idx_q;
    done_n    = '0;
    counter_n = counter_q;
    tgt_n     = tgt_q;
    last_n    = last_q;
    case (state)
      ST_IDLE: begin
        grant_n = '0;
        if (|REQ) begin
          grant_n   = NUM_REQ'(1) << pick;
          idx_n     = pick;
          counter_n = '0;
          tgt_n     = REQ_TARGET[int'(pick)*TARGET_WIDTH +: TARGET_WIDTH];
          last_n    = pick;
        end
      end
      ST_COUNT: begin
        if (!owner_req) begin
          grant_n = '0;
        end else if (at_target) begin
          done_n[idx_q] = 1'b1;
        end else if (TICK) begin
          counter_n = counter_q + TARGET_WIDTH'(1);
        end
      end
      ST_DONE: begin
        grant_n = '0;
      end
      default: begin
        grant_n = '0;
      end
    endcase
    busy_n = (next_state != ST_IDLE);
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      grant_q   <= '0;
      idx_q     <= '0;
      done_q    <= '0;
      busy_q    <= 1'b0;
      counter_q <= '0;
      tgt_q     <= '0;
      last_q    <= IDX_W'(NUM_REQ - 1);
    end else begin
      grant_q   <= grant_n;
      idx_q     <= idx_n;
      done_q    <= done_n;
      busy_q    <= busy_n;
      counter_q <= counter_n;
      tgt_q     <= tgt_n;
      last_q    <= last_n;
    end
  end

  assign GRANT     = grant_q;
  assign GRANT_IDX = idx_q;
  assign DONE      = done_q;
  assign BUSY      = busy_q;
  assign COUNTER   = counter_q;

endmodule
